sgmii_link_sequencer: RTL and testbench

Bring-up and recovery controller for the SGMII PCS/PMA core. It runs on the free-running independent clock and issues the PCS/PMA reset pulse. It then waits for transceiver reset-done and MMCM lock, and qualifies link status from status_vector. Failed attempts are retried with bounded timeouts, and link_up/fail are reported to the Ethernet MAC and control logic.

---
 rtl/sgmii_link_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sgmii_link_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sgmii_link_sequencer.sv
// Bring-up and recovery sequencer for the SGMII PCS/PMA core: pulses the core reset,
// waits for reset-done and MMCM lock, qualifies link status and retries with bounded timeouts.
module sgmii_link_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int DONE_TIMEOUT = 1048576,
  parameter int LINK_TIMEOUT = 4194304,
  parameter int LINK_STABLE  = 1024,
  parameter int MAX_RETRY    = 7,
  parameter int CNT_W        = 24
) (
  input  logic        independent_clock_bufg,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        readyforreset,
  input  logic        resetdone,
  input  logic        mmcm_locked,
  input  logic [15:0] status_vector,
  output logic        pcs_reset,
  output logic        link_up,
  output logic        fail,
  output logic [3:0]  retry_count,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ASSERT_RST = 3'd1;
  localparam logic [2:0] S_WAIT_DONE  = 3'd2;
  localparam logic [2:0] S_WAIT_LINK  = 3'd3;
  localparam logic [2:0] S_UP         = 3'd4;
  localparam logic [2:0] S_BACKOFF    = 3'd5;
  localparam logic [2:0] S_FAIL       = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DONE_LAST   = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LINK_LAST   = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LINK_STABLE - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  logic [1:0] done_sync;
  logic [1:0] lock_sync;
  logic [1:0] lstat_sync;
  logic [1:0] lsync_sync;
  logic       done_q;
  logic       lock_q;
  logic       link_q;
  logic       unused_status;

  logic [2:0]       state_nx;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nx;
  logic [CNT_W-1:0] timer_sat;
  logic [CNT_W-1:0] stab;
  logic [CNT_W-1:0] stab_nx;
  logic [CNT_W-1:0] stab_sat;
  logic [3:0]       retry_nx;
  logic [3:0]       retry_sat;
  logic             rst_nx;

  // Only link status and link sync are used from the PCS status word.
  assign unused_status = ^status_vector[15:2];

  always_ff @(posedge independent_clock_bufg or negedge reset_n) begin
    if (!reset_n) begin
      done_sync  <= 2'b00;
      lock_sync  <= 2'b00;
      lstat_sync <= 2'b00;
      lsync_sync <= 2'b00;
    end else begin
      done_sync  <= {done_sync[0], resetdone};
      lock_sync  <= {lock_sync[0], mmcm_locked};
      lstat_sync <= {lstat_sync[0], status_vector[0]};
      lsync_sync <= {lsync_sync[0], status_vector[1]};
    end
  end

  assign done_q = done_sync[1];
  assign lock_q = lock_sync[1];
  assign link_q = lstat_sync[1] & lsync_sync[1];

  assign timer_sat = (timer == CNT_MAX) ? timer : timer + CNT_ONE;
  assign stab_sat  = (stab == CNT_MAX) ? stab : stab + CNT_ONE;
  assign retry_sat = (retry_count == 4'hF) ? retry_count : retry_count + 4'd1;

  always_comb begin
    state_nx = state;
    timer_nx = timer_sat;
    stab_nx  = '0;
    retry_nx = retry_count;
    case (state)
      S_IDLE: begin
        timer_nx = '0;
        if (enable && readyforreset) begin
          state_nx = S_ASSERT_RST;
          retry_nx = 4'd0;
        end
      end
      S_ASSERT_RST: begin
        if (timer == RST_LAST) begin
          state_nx = S_WAIT_DONE;
          timer_nx = '0;
        end
      end
      S_WAIT_DONE: begin
        if (done_q && lock_q) begin
          state_nx = S_WAIT_LINK;
          timer_nx = '0;
        end else if (timer == DONE_LAST) begin
          state_nx = S_BACKOFF;
        end
      end
      S_WAIT_LINK: begin
        stab_nx = link_q ? stab_sat : '0;
        // A link that qualifies on the timeout cycle still counts as up.
        if (link_q && (stab == STABLE_LAST)) begin
          state_nx = S_UP;
        end else if (timer == LINK_LAST) begin
          state_nx = S_BACKOFF;
        end
      end
      S_UP: begin
        timer_nx = '0;
        if (!done_q || !lock_q) begin
          state_nx = S_BACKOFF;
        end else if (!link_q) begin
          state_nx = S_WAIT_LINK;
        end
      end
      S_BACKOFF: begin
        timer_nx = '0;
        // The attempt counter advances when the next reset pulse is launched.
        if (retry_count == RETRY_LIMIT) begin
          state_nx = S_FAIL;
        end else if (readyforreset) begin
          state_nx = S_ASSERT_RST;
          retry_nx = retry_sat;
        end
      end
      S_FAIL: begin
        timer_nx = '0;
      end
      default: begin
        state_nx = S_IDLE;
        timer_nx = '0;
      end
    endcase
    if (!enable) begin
      state_nx = S_IDLE;
      timer_nx = '0;
      stab_nx  = '0;
      retry_nx = retry_count;
    end
  end

  // Output flops are loaded from the next state so they change with the state itself.
  assign rst_nx = !((state_nx == S_WAIT_DONE) || (state_nx == S_WAIT_LINK) ||
                    (state_nx == S_UP));

  always_ff @(posedge independent_clock_bufg or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      stab        <= '0;
      retry_count <= 4'd0;
      pcs_reset   <= 1'b1;
      link_up     <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      stab        <= stab_nx;
      retry_count <= retry_nx;
      pcs_reset   <= rst_nx;
      link_up     <= (state_nx == S_UP);
      fail        <= (state_nx == S_FAIL);
    end
  end

endmodule

// File: tb/tb_sgmii_link_sequencer.sv
// Scoreboard bench for sgmii_link_sequencer: stimulus predicts timed output changes,
// a monitor matches every observed output change against the expected queue.
module tb_sgmii_link_sequencer;

  localparam int RST  = 16;
  localparam int DTO  = 64;
  localparam int LTO  = 1024;
  localparam int STB  = 128;
  localparam int MAXR = 2;
  localparam int W    = 42;
  localparam logic [9:0] RESET_VEC = 10'b000_1_0_0_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        readyforreset = 1'b0;
  logic        resetdone = 1'b0;
  logic        mmcm_locked = 1'b0;
  logic [15:0] status_vector = 16'h0000;
  logic        pcs_reset;
  logic        link_up;
  logic        fail;
  logic [3:0]  retry_count;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [9:0] prev_vec = RESET_VEC;
  logic [9:0] vec_now;
  logic [W-1:0] exp_q[$];

  sgmii_link_sequencer #(
    .RST_CYCLES(RST), .DONE_TIMEOUT(DTO), .LINK_TIMEOUT(LTO),
    .LINK_STABLE(STB), .MAX_RETRY(MAXR), .CNT_W(16)
  ) dut (
    .independent_clock_bufg(clk),
    .reset_n(reset_n),
    .enable(enable),
    .readyforreset(readyforreset),
    .resetdone(resetdone),
    .mmcm_locked(mmcm_locked),
    .status_vector(status_vector),
    .pcs_reset(pcs_reset),
    .link_up(link_up),
    .fail(fail),
    .retry_count(retry_count),
    .state(state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs follow from the state: reset held in IDLE/ASSERT/BACKOFF/FAIL.
  task automatic ev(input int at, input int st, input int rc);
    logic [2:0] s;
    logic [9:0] v;
    s = 3'(st);
    v = {s, (st == 0 || st == 1 || st == 5 || st == 6), (st == 4), (st == 6), 4'(rc)};
    exp_q.push_back({32'(at), v});
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_link(input logic l);
    logic [13:0] upper;
    upper = 14'($urandom());
    status_vector = {upper, 1'b1, l};
  endtask

  // monitor: compares every output change with the head of the queue
  always @(negedge clk) begin
    if (mon_en) begin
      vec_now = {state, pcs_reset, link_up, fail, retry_count};
      if (vec_now !== prev_vec) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        checks++;
        a = {32'(cyc), vec_now};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cycle %0d st=%0d pr=%0b lu=%0b fl=%0b rc=%0d",
                   cyc, vec_now[9:7], vec_now[6], vec_now[5], vec_now[4], vec_now[3:0]);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL output_change got cycle %0d st=%0d pr=%0b lu=%0b fl=%0b rc=%0d, expected cycle %0d st=%0d pr=%0b lu=%0b fl=%0b rc=%0d",
                     a[41:10], a[9:7], a[6], a[5], a[4], a[3:0],
                     e[41:10], e[9:7], e[6], e[5], e[4], e[3:0]);
          end
        end
      end
      prev_vec = vec_now;
    end
  end

  // watchdog
  initial begin
    repeat (30000) @(posedge clk);
    errors++;
    $display("FAIL watchdog expired at cycle %0d, expected end of stimulus", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int k, m, j, a, t, n, r, d, l;
    logic lv;
    logic [9:0] rv;

    // reset
    #1 reset_n = 1'b0;
    #2;
    rv = {state, pcs_reset, link_up, fail, retry_count};
    checks++;
    if (rv !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_state got %b expected %b", rv, RESET_VEC);
    end
    mon_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_to(cyc + 3);

    // bring-up with a readyforreset stall and random resetdone delay
    set_link(1'b1);
    enable = 1'b1;
    run_to(cyc + $urandom_range(0, 15));
    readyforreset = 1'b1;
    k = cyc;
    ev(k + 1, 1, 0);
    ev(k + 1 + RST, 2, 0);
    d = $urandom_range(1, 40);
    run_to(k + 1 + RST + d);
    resetdone = 1'b1;
    mmcm_locked = 1'b1;
    m = cyc;
    ev(m + 3, 3, 0);
    ev(m + 3 + STB, 4, 0);
    run_to(m + 3 + STB + 5);

    // short link drops in UP: requalify without a new reset pulse
    for (int i = 0; i < 3; i++) begin
      k = cyc;
      l = $urandom_range(1, 50);
      set_link(1'b0);
      ev(k + 3, 3, 0);
      ev(k + l + 2 + STB, 4, 0);
      run_to(k + l);
      set_link(1'b1);
      run_to(k + l + 2 + STB + 5);
    end

    // MMCM lock lost in UP, backoff stalled by readyforreset
    k = cyc;
    readyforreset = 1'b0;
    mmcm_locked = 1'b0;
    ev(k + 3, 5, 0);
    run_to(k + 3);
    mmcm_locked = 1'b1;
    run_to(k + 3 + $urandom_range(0, 20));
    readyforreset = 1'b1;
    j = cyc;
    ev(j + 1, 1, 1);
    ev(j + 1 + RST, 2, 1);
    ev(j + 2 + RST, 3, 1);
    ev(j + 2 + RST + STB, 4, 1);
    run_to(j + 2 + RST + STB + 5);

    // link toggling every 100 cycles never qualifies: link timeout
    k = cyc;
    lv = 1'b0;
    set_link(lv);
    t = k + 3 + LTO;
    ev(k + 3, 3, 1);
    ev(t, 5, 1);
    ev(t + 1, 1, 2);
    ev(t + 1 + RST, 2, 2);
    ev(t + 2 + RST, 3, 2);
    ev(t + 2 + RST + STB, 4, 2);
    n = 1;
    while (k + 100 * n < t) begin
      run_to(k + 100 * n);
      lv = ~lv;
      set_link(lv);
      n++;
    end
    run_to(t);
    set_link(1'b1);
    run_to(t + 2 + RST + STB + 5);

    // enable low in UP: IDLE next cycle, retry count held
    k = cyc;
    enable = 1'b0;
    resetdone = 1'b0;
    ev(k + 1, 0, 2);
    run_to(k + 5);

    // resetdone never rises: three pulses then FAIL
    k = cyc;
    enable = 1'b1;
    a = k + 1;
    for (int i = 0; i <= MAXR; i++) begin
      ev(a, 1, i);
      ev(a + RST, 2, i);
      ev(a + RST + DTO, 5, i);
      a = a + RST + DTO + 1;
    end
    ev(a, 6, MAXR);
    run_to(a + 10);

    // enable low in FAIL
    k = cyc;
    enable = 1'b0;
    ev(k + 1, 0, MAXR);
    run_to(k + 5);

    // asynchronous reset during WAIT_LINK, then recovery
    k = cyc;
    set_link(1'b0);
    resetdone = 1'b1;
    enable = 1'b1;
    ev(k + 1, 1, 0);
    ev(k + 1 + RST, 2, 0);
    ev(k + 2 + RST, 3, 0);
    r = $urandom_range(5, 200);
    run_to(k + 2 + RST + r);
    j = cyc;
    reset_n = 1'b0;
    ev(j, 0, 0);
    run_to(j + 3);
    set_link(1'b1);
    reset_n = 1'b1;
    ev(j + 4, 1, 0);
    ev(j + 4 + RST, 2, 0);
    ev(j + 5 + RST, 3, 0);
    ev(j + 5 + RST + STB, 4, 0);
    run_to(j + 5 + RST + STB + 10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
